// File: rtl/dm_axi_slave.sv
// dm_axi_slave: AXI4 slave turning AR/R and AW/W/B bursts into single-port data-memory SRAM accesses
// Ports: clk, rst (async active-low); AXI AW/W/B and AR/R channels (ID_W-bit IDs, 32-bit data,
// 4-bit LEN, FIXED/INCR bursts); DM_CEB/DM_WEB/DM_BWEB (active-low), DM_A, DM_DI, DM_DO to the SRAM macro.
// Build option: define DM_PROTOCOL_CHECK_EN to return SLVERR on illegal size/burst or misplaced WLAST.
module dm_axi_slave #(
  parameter int ID_W = 8,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    AWID,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [ID_W-1:0]    BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [ID_W-1:0]    ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               DM_CEB,
  output logic               DM_WEB,
  output logic [31:0]        DM_BWEB,
  output logic [SRAM_AW-1:0] DM_A,
  output logic [31:0]        DM_DI,
  input  logic [31:0]        DM_DO
);
  localparam logic [2:0] IDLE = 3'd0, WR_DATA = 3'd1, WR_RESP = 3'd2, RD_ADDR = 3'd3, RD_DATA = 3'd4;
`ifdef DM_PROTOCOL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic [2:0] state;
  logic [ID_W-1:0] id;
  logic [SRAM_AW-1:0] addr, a_q, nxt_addr;
  logic [31:0] di_q;
  logic [3:0] len, cnt;
  logic fixed, err, w_hs, rd_acc, last;
  assign w_hs = state == WR_DATA && WVALID;
  // an erroneous read never touches the SRAM
  assign rd_acc = state == RD_ADDR && !err;
  assign last = cnt == len;
  assign nxt_addr = fixed ? addr : addr + 1'b1;
  assign AWREADY = state == IDLE;
  assign ARREADY = state == IDLE && !AWVALID;
  assign WREADY = state == WR_DATA;
  assign BVALID = state == WR_RESP;
  assign BID = id;
  assign BRESP = err ? 2'b10 : 2'b00;
  assign RVALID = state == RD_DATA;
  assign RID = id;
  assign RRESP = err ? 2'b10 : 2'b00;
  assign RLAST = RVALID && last;
  // DO is held by the macro because no access happens while RVALID is up
  assign RDATA = RVALID && !err ? DM_DO : 32'h0;
  assign DM_CEB = !(w_hs || rd_acc);
  assign DM_WEB = !w_hs;
  assign DM_BWEB = w_hs ? ~{{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}} : 32'hFFFF_FFFF;
  assign DM_A = (w_hs || rd_acc) ? addr : a_q;
  assign DM_DI = w_hs ? WDATA : di_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      id <= '0;
      addr <= '0;
      a_q <= '0;
      di_q <= '0;
      len <= '0;
      cnt <= '0;
      fixed <= 1'b0;
      err <= 1'b0;
    end else begin
      if (w_hs || rd_acc) a_q <= addr;
      if (w_hs) di_q <= WDATA;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (AWVALID) begin
            state <= WR_DATA;
            id <= AWID;
            addr <= AWADDR[SRAM_AW+1:2];
            len <= AWLEN;
            fixed <= AWBURST == 2'b00;
            err <= CHK && (AWSIZE != 3'b010 || AWBURST[1]);
          end else if (ARVALID) begin
            state <= RD_ADDR;
            id <= ARID;
            addr <= ARADDR[SRAM_AW+1:2];
            len <= ARLEN;
            fixed <= ARBURST == 2'b00;
            err <= CHK && (ARSIZE != 3'b010 || ARBURST[1]);
          end
        end
        WR_DATA: if (WVALID) begin
          err <= err || (CHK && (WLAST != last));
          state <= last ? WR_RESP : WR_DATA;
          cnt <= last ? '0 : cnt + 1'b1;
          addr <= last ? addr : nxt_addr;
        end
        WR_RESP: state <= BREADY ? IDLE : WR_RESP;
        RD_ADDR: state <= RD_DATA;
        RD_DATA: if (RREADY) begin
          state <= last ? IDLE : RD_ADDR;
          cnt <= last ? '0 : cnt + 1'b1;
          addr <= last ? addr : nxt_addr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_axi_slave.sv
// tb_dm_axi_slave: directed bench for dm_axi_slave with a behavioural SRAM macro model
module tb_dm_axi_slave;
  logic clk = 1'b0, rst = 1'b0, preload = 1'b1;
  logic [7:0] AWID = '0, ARID = '0, BID, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA, DM_BWEB, DM_DI, DM_DO;
  logic [3:0] AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0] AWSIZE = 3'b010, ARSIZE = 3'b010;
  logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID, DM_CEB, DM_WEB;
  logic [13:0] DM_A;
  logic [31:0] mem [0:16383];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  dm_axi_slave #(.ID_W(8), .SRAM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .DM_CEB(DM_CEB), .DM_WEB(DM_WEB), .DM_BWEB(DM_BWEB), .DM_A(DM_A), .DM_DI(DM_DI), .DM_DO(DM_DO)
  );

  // SRAM macro: word i preloads to {16'hA5A5, i}; DO updates only on a read access
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16384; i++) mem[i] <= {16'hA5A5, 2'b00, i[13:0]};
      DM_DO <= '0;
    end else if (!DM_CEB) begin
      if (!DM_WEB) mem[DM_A] <= (mem[DM_A] & DM_BWEB) | (DM_DI & ~DM_BWEB);
      else DM_DO <= mem[DM_A];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [7:0] i);
    AWADDR = a; AWLEN = l; AWBURST = b; AWID = i; AWSIZE = 3'b010; AWVALID = 1;
    #1 chk("awready", AWREADY, 1);
    @(negedge clk);
    AWVALID = 0;
  endtask

  task automatic ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [7:0] i);
    ARADDR = a; ARLEN = l; ARBURST = b; ARID = i; ARSIZE = 3'b010; ARVALID = 1;
    #1 chk("arready", ARREADY, 1);
    @(negedge clk);
    ARVALID = 0;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic [13:0] ea,
                         input logic [31:0] ebweb);
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1;
    #1;
    chk("wready", WREADY, 1);
    chk("wr_ceb", DM_CEB, 0);
    chk("wr_web", DM_WEB, 0);
    chk("wr_a", DM_A, ea);
    chk("wr_bweb", DM_BWEB, ebweb);
    chk("wr_di", DM_DI, d);
    @(negedge clk);
    WVALID = 0; WLAST = 0;
  endtask

  task automatic b_chk(input logic [7:0] i, input logic [1:0] r);
    #1;
    chk("bvalid", BVALID, 1);
    chk("bid", BID, i);
    chk("bresp", BRESP, r);
    BREADY = 1;
    @(negedge clk);
    BREADY = 0;
    #1 chk("bvalid_drop", BVALID, 0);
  endtask

  task automatic rd_beat(input logic [13:0] ea, input logic [31:0] ed, input logic el, input int stall,
                         input logic [7:0] i);
    #1;
    chk("rd_rvalid_lo", RVALID, 0);
    chk("rd_ceb", DM_CEB, 0);
    chk("rd_web", DM_WEB, 1);
    chk("rd_bweb", DM_BWEB, 32'hFFFF_FFFF);
    chk("rd_a", DM_A, ea);
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      chk("stall_rvalid", RVALID, 1);
      chk("stall_rdata", RDATA, ed);
      chk("stall_ceb", DM_CEB, 1);
      @(negedge clk);
    end
    chk("rvalid", RVALID, 1);
    chk("rdata", RDATA, ed);
    chk("rlast", RLAST, el);
    chk("rid", RID, i);
    chk("rresp", RRESP, 0);
    chk("rdata_ceb", DM_CEB, 1);
    RREADY = 1;
    @(negedge clk);
    RREADY = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    preload = 0;
    #1;
    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_ceb", DM_CEB, 1);
    chk("rst_web", DM_WEB, 1);
    chk("rst_bweb", DM_BWEB, 32'hFFFF_FFFF);
    AWVALID = 1;
    #1 chk("rst_arready_aw", ARREADY, 0);
    AWVALID = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    // single partial-strobe write then read back
    aw(32'h10, 0, 2'b01, 8'h3C);
    wr_beat(32'hDEADBEEF, 4'b0011, 1, 14'd4, 32'hFFFF_0000);
    b_chk(8'h3C, 2'b00);
    chk("idle_ceb", DM_CEB, 1);
    chk("idle_a_hold", DM_A, 4);
    chk("idle_di_hold", DM_DI, 32'hDEADBEEF);
    ar(32'h10, 0, 2'b01, 8'h5A);
    rd_beat(14'd4, 32'hA5A5BEEF, 1, 0, 8'h5A);
    #1 chk("rvalid_drop", RVALID, 0);
    // 4-beat INCR write and read, read beat 2 stalled for 5 cycles
    aw(32'h100, 3, 2'b01, 8'h01);
    for (int k = 0; k < 4; k++) wr_beat(32'h11110000 + k, 4'hF, k == 3, 14'(64 + k), 32'h0);
    b_chk(8'h01, 2'b00);
    ar(32'h100, 3, 2'b01, 8'h02);
    for (int k = 0; k < 4; k++) rd_beat(14'(64 + k), 32'h11110000 + k, k == 3, k == 1 ? 5 : 0, 8'h02);
    #1 chk("burst_done", RVALID, 0);
    // simultaneous AW and AR: write wins, read follows BREADY
    AWADDR = 32'h20; AWLEN = 0; AWBURST = 2'b01; AWID = 8'h07; AWVALID = 1;
    ARADDR = 32'h20; ARLEN = 0; ARBURST = 2'b01; ARID = 8'h09; ARVALID = 1;
    #1;
    chk("sim_awready", AWREADY, 1);
    chk("sim_arready", ARREADY, 0);
    @(negedge clk);
    AWVALID = 0;
    #1 chk("sim_arready_wd", ARREADY, 0);
    wr_beat(32'hCAFEF00D, 4'hF, 1, 14'd8, 32'h0);
    #1 chk("sim_arready_wr", ARREADY, 0);
    b_chk(8'h07, 2'b00);
    chk("sim_arready_idle", ARREADY, 1);
    @(negedge clk);
    ARVALID = 0;
    rd_beat(14'd8, 32'hCAFEF00D, 1, 0, 8'h09);
    // INCR wrap at the top of the array, then FIXED and INCR reads of it
    aw(32'hFFFC, 1, 2'b01, 8'h11);
    wr_beat(32'h01234567, 4'hF, 0, 14'd16383, 32'h0);
    wr_beat(32'h89ABCDEF, 4'hF, 1, 14'd0, 32'h0);
    b_chk(8'h11, 2'b00);
    ar(32'hFFFC, 1, 2'b00, 8'h12);
    rd_beat(14'd16383, 32'h01234567, 0, 0, 8'h12);
    rd_beat(14'd16383, 32'h01234567, 1, 0, 8'h12);
    ar(32'hFFFC, 1, 2'b01, 8'h13);
    rd_beat(14'd16383, 32'h01234567, 0, 0, 8'h13);
    rd_beat(14'd0, 32'h89ABCDEF, 1, 0, 8'h13);
    // reset during beat 3 of an 8-beat read
    ar(32'h100, 7, 2'b01, 8'h20);
    rd_beat(14'd64, 32'h11110000, 0, 0, 8'h20);
    rd_beat(14'd65, 32'h11110001, 0, 0, 8'h20);
    #1 chk("b3_a", DM_A, 66);
    @(negedge clk);
    chk("b3_rvalid", RVALID, 1);
    chk("b3_rdata", RDATA, 32'h11110002);
    rst = 0;
    #1;
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_rlast", RLAST, 0);
    chk("mid_rst_awready", AWREADY, 1);
    chk("mid_rst_ceb", DM_CEB, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_rvalid", RVALID, 0);
    chk("post_rst_bvalid", BVALID, 0);
    ar(32'h100, 0, 2'b01, 8'h21);
    rd_beat(14'd64, 32'h11110000, 1, 0, 8'h21);
`ifdef DM_PROTOCOL_CHECK_EN
    aw(32'h200, 3, 2'b01, 8'h30);
    wr_beat(32'h22220000, 4'hF, 0, 14'd128, 32'h0);
    wr_beat(32'h22220001, 4'hF, 1, 14'd129, 32'h0);
    wr_beat(32'h22220002, 4'hF, 0, 14'd130, 32'h0);
    wr_beat(32'h22220003, 4'hF, 1, 14'd131, 32'h0);
    b_chk(8'h30, 2'b10);
    ar(32'h100, 0, 2'b10, 8'h31);
    #1 chk("bad_rd_ceb", DM_CEB, 1);
    @(negedge clk);
    chk("bad_rd_rvalid", RVALID, 1);
    chk("bad_rd_rdata", RDATA, 0);
    chk("bad_rd_rresp", RRESP, 2'b10);
    RREADY = 1;
    @(negedge clk);
    RREADY = 0;
    ar(32'h200, 0, 2'b01, 8'h32);
    rd_beat(14'd128, 32'h22220000, 1, 0, 8'h32);
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
